mix_columns_iter: RTL and testbench

- Iterative forward AES MixColumns engine for the encryption datapath. It is the counterpart of the existing combinational InvMixColumns used on the decryption side.
- Accepts a 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock.
- Holds the result until downstream accepts it.
- A per-transfer skip flag passes the state through unchanged with identical latency, so the final AES round keeps uniform timing.

---
 rtl/mix_columns_iter.sv | 134 +++++++++++++
 tb/tb_mix_columns_iter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_iter.sv
// Iterative forward AES MixColumns: transforms COLS_PER_CYCLE columns per clock.
// Latency 4/COLS_PER_CYCLE cycles from input accept to out_valid; skip keeps identical timing.
// Result held in DONE until out_ready; a new state may be accepted in the same cycle.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  input  logic         in_skip,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // The step wraps to 0 when all four columns go in one cycle; the counter is unused then.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [0:127] work_q, work_d;
  logic         skip_q, skip_d;

  logic [1:0]   slot_idx [COLS_PER_CYCLE];
  logic [31:0]  slot_in  [COLS_PER_CYCLE];
  logic [31:0]  slot_mix [COLS_PER_CYCLE];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column word holds byte 0 in [31:24] down to byte 3 in [7:0].
  function automatic logic [31:0] mix_col(input logic [31:0] s);
    logic [7:0] s0, s1, s2, s3;
    logic [7:0] d0, d1, d2, d3;
    s0 = s[31:24];
    s1 = s[23:16];
    s2 = s[15:8];
    s3 = s[7:0];
    d0 = xtime(s0);
    d1 = xtime(s1);
    d2 = xtime(s2);
    d3 = xtime(s3);
    return {d0 ^ d1 ^ s1 ^ s2 ^ s3,
            s0 ^ d1 ^ d2 ^ s2 ^ s3,
            s0 ^ s1 ^ d2 ^ d3 ^ s3,
            d0 ^ s0 ^ s1 ^ s2 ^ d3};
  endfunction

  // Only COLS_PER_CYCLE mixers exist; each one is steered to its column by the counter.
  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_slot
    assign slot_idx[i] = col_q + 2'(i);
    assign slot_in[i]  = work_q[32*slot_idx[i] +: 32];
    assign slot_mix[i] = mix_col(slot_in[i]);
  end

  assign out_state = work_q;

  // Next-state, working-register update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    work_d    = work_q;
    skip_d    = skip_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_state;
          skip_d  = in_skip;
          col_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
          work_d[32*slot_idx[i] +: 32] = skip_q ? slot_in[i] : slot_mix[i];
        end
        col_d = col_q + COL_STEP;
        if (col_q == LAST_COL) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            work_d  = in_state;
            skip_d  = in_skip;
            col_d   = 2'd0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      work_q  <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
      skip_q  <= skip_d;
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter at COLS_PER_CYCLE = 1, 2, 4.
// Directed vector table, hand sequences for backpressure/back-to-back/reset, random round trip.
// Outputs sampled at the falling edge; inputs driven 1 time unit after the rising edge.
module tb_mix_columns_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         iv   [3];
  logic         ir   [3];
  logic         isk  [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [0:127] ist  [3];
  logic [0:127] ost  [3];

  mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(ist[0]),
    .in_skip(isk[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(ost[0]));
  mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(ist[1]),
    .in_skip(isk[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(ost[1]));
  mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(ist[2]),
    .in_skip(isk[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(ost[2]));

  int checks = 0;
  int errors = 0;

  localparam logic [0:127] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [0:127] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [0:127] KNOWN_IN = 128'hdb1353450a0a0a0a01010101c6c6c6c6;
  localparam logic [0:127] KNOWN_OUT= 128'h8e4da1bc0a0a0a0a01010101c6c6c6c6;
  localparam logic [0:127] SKIP_IN  = 128'hf20a225c2d26314cd4bf5d30db135345;
  localparam logic [0:127] B2B_IN   = 128'hf20a225cf20a225cf20a225cf20a225c;
  localparam logic [0:127] B2B_OUT  = 128'h9fdc589d9fdc589d9fdc589d9fdc589d;

  typedef struct {
    int           k;
    logic [0:127] st;
    logic         sk;
    logic [0:127] exp;
    int           lat;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // GF(2^8) multiply by shift-and-add under the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product per column: forward {2,3,1,1} or inverse {e,b,d,9}.
  function automatic logic [0:127] mixc(input logic [0:127] s, input bit inv);
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    logic [0:127] r;
    if (inv) begin
      cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    end else begin
      cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(s[32*c+8*j +: 8], cf[(j - row + 4) % 4]);
        end
        r[32*c+8*row +: 8] = acc;
      end
    end
    return r;
  endfunction

  // Present a state and hold it until accepted; returns just after the transfer edge.
  task automatic send(input int k, input logic [0:127] st, input logic sk);
    int n;
    n = 0;
    ist[k] = st;
    isk[k] = sk;
    iv[k]  = 1'b1;
    @(negedge clk);
    while (!ir[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir[k]) fail_now("send_accept");
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
  endtask

  // Count rising edges from the transfer edge until out_valid; returns at a falling edge.
  task automatic wait_out(input int k, output int lat);
    lat = 0;
    @(negedge clk);
    while (!ov[k] && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!ov[k]) fail_now("wait_out_valid");
  endtask

  task automatic run_random(input int k, input int n);
    logic [0:127] q_st [$];
    logic         q_sk [$];
    logic [0:127] e;
    logic         esk;
    logic         xfer;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; xfer = 1'b0;
    iv[k] = 1'b0;
    ordy[k] = 1'b0;
    while (got < n && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (xfer) iv[k] = 1'b0;
      if (!iv[k] && sent < n && $urandom_range(0, 2) != 0) begin
        ist[k] = {$urandom, $urandom, $urandom, $urandom};
        isk[k] = ($urandom_range(0, 7) == 0);
        iv[k]  = 1'b1;
      end
      ordy[k] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (ov[k] && ordy[k]) begin
        if (q_st.size() == 0) begin
          fail_now("rand_unexpected_output");
        end else begin
          e   = q_st.pop_front();
          esk = q_sk.pop_front();
          chk("rand_fwd", ost[k], esk ? e : mixc(e, 1'b0));
          if (!esk) chk("rand_roundtrip", mixc(ost[k], 1'b1), e);
          got++;
        end
      end
      xfer = iv[k] && ir[k];
      if (xfer) begin
        q_st.push_back(ist[k]);
        q_sk.push_back(isk[k]);
        sent++;
      end
    end
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    ordy[k] = 1'b0;
    chk("rand_count", 128'(got), 128'(n));
    chk("rand_leftover", 128'(q_st.size()), 128'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    tbl[0] = '{0, FIPS_IN,  1'b0, FIPS_OUT,  4};
    tbl[1] = '{0, KNOWN_IN, 1'b0, KNOWN_OUT, 4};
    tbl[2] = '{1, KNOWN_IN, 1'b0, KNOWN_OUT, 2};
    tbl[3] = '{2, KNOWN_IN, 1'b0, KNOWN_OUT, 1};
    tbl[4] = '{0, SKIP_IN,  1'b1, SKIP_IN,   4};
    tbl[5] = '{1, FIPS_IN,  1'b0, FIPS_OUT,  2};
    tbl[6] = '{2, SKIP_IN,  1'b1, SKIP_IN,   1};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; isk[k] = 1'b0; ist[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_in_ready",  128'(ir[k]), 128'd1);
      chk("reset_out_valid", 128'(ov[k]), 128'd0);
      chk("reset_out_state", ost[k], 128'd0);
    end
    @(posedge clk);
    #1;

    // Directed vectors, one per table row.
    for (int i = 0; i < 7; i++) begin
      ordy[tbl[i].k] = 1'b1;
      send(tbl[i].k, tbl[i].st, tbl[i].sk);
      wait_out(tbl[i].k, lat);
      chk("vec_latency", 128'(lat), 128'(tbl[i].lat));
      chk("vec_out_state", ost[tbl[i].k], tbl[i].exp);
      @(posedge clk);
      #1;
      chk("vec_back_to_idle", 128'(ir[tbl[i].k]), 128'd1);
      ordy[tbl[i].k] = 1'b0;
    end

    // Skip with output held back for six cycles.
    ordy[0] = 1'b0;
    send(0, SKIP_IN, 1'b1);
    wait_out(0, lat);
    chk("skip_latency", 128'(lat), 128'd4);
    chk("skip_out_state", ost[0], SKIP_IN);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_out_valid", 128'(ov[0]), 128'd1);
      chk("hold_out_state", ost[0], SKIP_IN);
      chk("hold_in_ready", 128'(ir[0]), 128'd0);
    end

    // Back-to-back: next state accepted on the same edge as the held result.
    ist[0] = B2B_IN; isk[0] = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b1;
    #1;
    chk("b2b_in_ready", 128'(ir[0]), 128'd1);
    chk("b2b_first_state", ost[0], SKIP_IN);
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    #1;
    chk("b2b_busy_in_ready", 128'(ir[0]), 128'd0);
    chk("b2b_busy_out_valid", 128'(ov[0]), 128'd0);
    wait_out(0, lat);
    chk("b2b_latency", 128'(lat), 128'd4);
    chk("b2b_out_state", ost[0], B2B_OUT);
    @(posedge clk);
    #1;

    // Reset two cycles into a transform.
    send(0, FIPS_IN, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 128'(ov[0]), 128'd0);
    chk("midrst_out_state", ost[0], 128'd0);
    chk("midrst_in_ready", 128'(ir[0]), 128'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    chk("midrst_discarded", 128'(seen), 128'd0);
    @(posedge clk);
    #1;
    send(0, KNOWN_IN, 1'b0);
    wait_out(0, lat);
    chk("postrst_latency", 128'(lat), 128'd4);
    chk("postrst_out_state", ost[0], KNOWN_OUT);
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;

    // Random traffic with gaps on both sides, every width.
    for (int k = 0; k < 3; k++) run_random(k, 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
